data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder for the processor's data port: answers load/store requests from the pipeline's Execute/Memory1 stages.
- Implements the DataAddr / DataOut / ReadData / WriteData / DataIn / DataDone handshake with a configurable number of wait states.
- Contains a word-addressed memory array plus a side load port that testbenches use to preload data.
- Sits between the processor core and the system top level; it replaces the ideal zero-latency data memory model.

Parameters:
WORD_SIZE, 16, data and address width in bits
DEPTH, 256, number of words in the array; must be a power of two
WAIT_STATES, 2, cycles DataDone is held low per access; 0 means single-cycle responses
ADDR_BITS, $clog2(DEPTH), derived array index width; not overridden

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
DataAddr  input  WORD_SIZE  request word address from processor
DataOut  input  WORD_SIZE  store data from processor
ReadData  input  1  load request
WriteData  input  1  store request
DataIn  output  WORD_SIZE  load result to processor
DataDone  output  1  high = responder ready / previous access complete
LoadEn  input  1  side-port write strobe (testbench preload)
LoadAddr  input  WORD_SIZE  side-port word address
LoadData  input  WORD_SIZE  side-port write data

Behaviour:
- Reset (async): state=IDLE, DataDone=1, DataIn=0, wait counter=0, latched request cleared. Memory contents are not cleared. An in-flight access is aborted and its store is not committed.
- Address index is DataAddr[ADDR_BITS-1:0]; upper bits are ignored, so addresses wrap modulo DEPTH. The same rule applies to LoadAddr.
- States: IDLE and BUSY.
- IDLE:
  - DataDone=1.
  - On a rising edge with ReadData|WriteData=1, latch the address, store data and operation.
  - If ReadData and WriteData are both 1, the access is treated as a store; the read is dropped.
- WAIT_STATES=0:
  - The access executes on the accepting edge and the state stays IDLE.
  - A store commits at that edge.
  - A load registers mem[idx] into DataIn, valid the following cycle while DataDone=1.
  - Back-to-back accesses run every cycle.
- WAIT_STATES>0:
  - The accepting edge moves IDLE->BUSY and loads counter=WAIT_STATES.
  - In BUSY: DataDone=0, the counter decrements each edge, and ReadData/WriteData/DataAddr/DataOut are ignored (the processor re-drives the same request while stalled).
  - On the edge where the counter equals 1, the latched access executes (store commits / DataIn loaded) and the state goes to IDLE.
  - DataDone is therefore low for exactly WAIT_STATES cycles per access.
- Completion cycle: DataDone=1 and DataIn is valid. A new request presented that cycle is accepted on the next edge, so there is no dead cycle between accesses.
- DataIn holds the most recent load result until the next load completes; stores and side-port loads never change DataIn.
- Load port:
  - LoadEn writes LoadData at the edge in any state.
  - If a processor store commits to the same index on the same edge, the processor store wins.
  - A processor load executing on the same edge as a LoadEn to the same index returns the old contents (read-before-write).
- No request (ReadData=WriteData=0) in IDLE: no state change, DataIn unchanged.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds three outputs, each WORD_SIZE wide:
  - ReadCount: completed loads.
  - WriteCount: committed stores.
  - StallCount: cycles with DataDone=0.
  - All three reset to 0, saturate at all-ones, and count on the same edge as the event.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- WAIT_STATES=0: preload mem[5]=0x1234 via LoadEn; ReadData=1, DataAddr=5 for one cycle -> next cycle DataIn=0x1234, DataDone stays 1 throughout.
- WAIT_STATES=2: WriteData=1, DataAddr=7, DataOut=0xBEEF, held while stalled -> DataDone=0 for exactly 2 cycles; then read addr 7 -> DataIn=0xBEEF after 2 more low cycles.
- WAIT_STATES=2: store to addr 3 followed on the completion cycle by a load of addr 3 -> load accepted on the very next edge, returns the new value; no idle gap.
- DEPTH=256: load DataAddr=0x0105 after preload mem[5]=0x00AA -> DataIn=0x00AA (wrap).
- Assert Reset mid-BUSY during a store of 0x5555 to addr 9 (mem[9]=0x1111 before) -> DataDone=1 and DataIn=0 immediately; a subsequent read of addr 9 returns 0x1111.
- DMEM_STATS_EN, WAIT_STATES=1: 3 loads + 2 stores -> ReadCount=3, WriteCount=2, StallCount=5.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array with DataDone handshake and configurable wait states.
// Optional access/stall counters enabled by defining DMEM_STATS_EN.
module data_mem_responder #(
  parameter int WORD_SIZE   = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_BITS   = $clog2(DEPTH)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone,
  input  logic                 LoadEn,
  input  logic [WORD_SIZE-1:0] LoadAddr,
  input  logic [WORD_SIZE-1:0] LoadData
`ifdef DMEM_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] ReadCount,
  output logic [WORD_SIZE-1:0] WriteCount,
  output logic [WORD_SIZE-1:0] StallCount
`endif
);

  localparam int CW = (WAIT_STATES > 0) ?
                      $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_INIT = CW'(WAIT_STATES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [WORD_SIZE-1:0] r_mem [DEPTH];
  logic [0:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [ADDR_BITS-1:0] r_idx;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_wr;
  logic [WORD_SIZE-1:0] r_din;

  logic                 w_req;
  logic                 w_acc;
  logic                 w_exec;
  logic                 w_wr;
  logic [ADDR_BITS-1:0] w_idx;
  logic [WORD_SIZE-1:0] w_wdata;
  logic [ADDR_BITS-1:0] w_lidx;
  logic                 w_unused_addr;

  assign w_req  = ReadData | WriteData;
  assign w_acc  = (r_state == S_IDLE) && w_req;
  assign w_lidx = LoadAddr[ADDR_BITS-1:0];

  assign w_unused_addr = ^{DataAddr[WORD_SIZE-1:ADDR_BITS],
                           LoadAddr[WORD_SIZE-1:ADDR_BITS]};

  // Zero wait states execute straight from the port; otherwise from the latch.
  always_comb begin
    w_exec  = 1'b0;
    w_wr    = 1'b0;
    w_idx   = '0;
    w_wdata = '0;
    if (WAIT_STATES == 0) begin
      w_exec  = w_acc && !Reset;
      w_wr    = WriteData;
      w_idx   = DataAddr[ADDR_BITS-1:0];
      w_wdata = DataOut;
    end else begin
      w_exec  = (r_state == S_BUSY) && (r_cnt == ONE);
      w_wr    = r_wr;
      w_idx   = r_idx;
      w_wdata = r_wdata;
    end
  end

  // Later assignment wins: processor store beats side-port load.
  always_ff @(posedge Clock) begin
    if (LoadEn)
      r_mem[w_lidx] <= LoadData;
    if (w_exec && w_wr)
      r_mem[w_idx] <= w_wdata;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_din   <= '0;
    end else begin
      if (w_acc) begin
        r_idx   <= DataAddr[ADDR_BITS-1:0];
        r_wdata <= DataOut;
        r_wr    <= WriteData;
      end
      if (w_exec && !w_wr)
        r_din <= r_mem[w_idx];
      if (WAIT_STATES != 0) begin
        if (w_acc) begin
          r_state <= S_BUSY;
          r_cnt   <= WS_INIT;
        end else if (r_state == S_BUSY) begin
          r_cnt <= r_cnt - ONE;
          if (r_cnt == ONE)
            r_state <= S_IDLE;
        end
      end
    end
  end

  assign DataIn   = r_din;
  assign DataDone = (r_state == S_IDLE);

`ifdef DMEM_STATS_EN
  logic [WORD_SIZE-1:0] r_rd_cnt;
  logic [WORD_SIZE-1:0] r_wr_cnt;
  logic [WORD_SIZE-1:0] r_st_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_st_cnt <= '0;
    end else begin
      if (w_exec && !w_wr && r_rd_cnt != '1)
        r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_exec && w_wr && r_wr_cnt != '1)
        r_wr_cnt <= r_wr_cnt + 1'b1;
      if (r_state == S_BUSY && r_st_cnt != '1)
        r_st_cnt <= r_st_cnt + 1'b1;
    end
  end

  assign ReadCount  = r_rd_cnt;
  assign WriteCount = r_wr_cnt;
  assign StallCount = r_st_cnt;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instances with 0, 2 and 1 wait states.
// Counter checks are compiled in when DMEM_STATS_EN is defined.
module tb_data_mem_responder;

  logic        Clock;
  logic        Reset;
  logic        rd   [3];
  logic        wr   [3];
  logic [15:0] addr [3];
  logic [15:0] dout [3];
  logic [15:0] din  [3];
  logic        done [3];
  logic        le   [3];
  logic [15:0] la   [3];
  logic [15:0] ld   [3];

  int n_vec;
  int n_bad;
  int st;

`ifdef DMEM_STATS_EN
  logic [15:0] rc [3];
  logic [15:0] wc [3];
  logic [15:0] sc [3];
`endif

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  data_mem_responder #(.WAIT_STATES(0)) u_ws0 (
    .Clock(Clock), .Reset(Reset),
    .DataAddr(addr[0]), .DataOut(dout[0]),
    .ReadData(rd[0]), .WriteData(wr[0]),
    .DataIn(din[0]), .DataDone(done[0]),
    .LoadEn(le[0]), .LoadAddr(la[0]), .LoadData(ld[0])
`ifdef DMEM_STATS_EN
    , .ReadCount(rc[0]), .WriteCount(wc[0]), .StallCount(sc[0])
`endif
  );

  data_mem_responder #(.WAIT_STATES(2)) u_ws2 (
    .Clock(Clock), .Reset(Reset),
    .DataAddr(addr[1]), .DataOut(dout[1]),
    .ReadData(rd[1]), .WriteData(wr[1]),
    .DataIn(din[1]), .DataDone(done[1]),
    .LoadEn(le[1]), .LoadAddr(la[1]), .LoadData(ld[1])
`ifdef DMEM_STATS_EN
    , .ReadCount(rc[1]), .WriteCount(wc[1]), .StallCount(sc[1])
`endif
  );

  data_mem_responder #(.WAIT_STATES(1)) u_ws1 (
    .Clock(Clock), .Reset(Reset),
    .DataAddr(addr[2]), .DataOut(dout[2]),
    .ReadData(rd[2]), .WriteData(wr[2]),
    .DataIn(din[2]), .DataDone(done[2]),
    .LoadEn(le[2]), .LoadAddr(la[2]), .LoadData(ld[2])
`ifdef DMEM_STATS_EN
    , .ReadCount(rc[2]), .WriteCount(wc[2]), .StallCount(sc[2])
`endif
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int k,
                         input logic [15:0] a,
                         input logic [15:0] d);
    le[k] = 1'b1;
    la[k] = a;
    ld[k] = d;
    @(posedge Clock);
    #1;
    le[k] = 1'b0;
  endtask

  // Holds the request until DataDone returns; leaves us in the completion cycle.
  task automatic access(input int k, input logic isw,
                        input logic [15:0] a,
                        input logic [15:0] d,
                        output int stalls);
    rd[k]   = !isw;
    wr[k]   = isw;
    addr[k] = a;
    dout[k] = d;
    stalls  = 0;
    @(posedge Clock);
    #1;
    le[k] = 1'b0;
    while (done[k] !== 1'b1 && stalls < 20) begin
      stalls++;
      @(posedge Clock);
      #1;
    end
    if (stalls >= 20)
      chk("timeout", {15'd0, done[k]}, 16'd1);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 0; wr[k] = 0; addr[k] = 0; dout[k] = 0;
      le[k] = 0; la[k] = 0; ld[k] = 0;
    end
    repeat (2) @(posedge Clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_done", {15'd0, done[k]}, 16'd1);
      chk("rst_din", din[k], 16'h0000);
    end
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    // zero wait states
    preload(0, 16'd5, 16'h1234);
    access(0, 1'b0, 16'd5, 16'h0, st);
    chk("ws0_stall", 16'(st), 16'd0);
    chk("ws0_load", din[0], 16'h1234);
    preload(0, 16'd5, 16'h00AA);
    access(0, 1'b0, 16'h0105, 16'h0, st);
    chk("wrap_load", din[0], 16'h00AA);
    le[0] = 1'b1; la[0] = 16'd5; ld[0] = 16'h7777;
    access(0, 1'b0, 16'd5, 16'h0, st);
    chk("rbw_old", din[0], 16'h00AA);
    access(0, 1'b0, 16'd5, 16'h0, st);
    chk("rbw_new", din[0], 16'h7777);
    le[0] = 1'b1; la[0] = 16'd6; ld[0] = 16'h2222;
    access(0, 1'b1, 16'd6, 16'h1111, st);
    chk("st_keeps_din", din[0], 16'h7777);
    access(0, 1'b0, 16'd6, 16'h0, st);
    chk("st_beats_le", din[0], 16'h1111);

    // two wait states
    access(1, 1'b1, 16'd7, 16'hBEEF, st);
    chk("ws2_st_stall", 16'(st), 16'd2);
    access(1, 1'b0, 16'd7, 16'h0, st);
    chk("ws2_ld_stall", 16'(st), 16'd2);
    chk("ws2_load", din[1], 16'hBEEF);
    access(1, 1'b1, 16'd3, 16'h3333, st);
    chk("b2b_done", {15'd0, done[1]}, 16'd1);
    access(1, 1'b0, 16'd3, 16'h0, st);
    chk("b2b_stall", 16'(st), 16'd2);
    chk("b2b_load", din[1], 16'h3333);

    // reset in the middle of a stalled store
    preload(1, 16'd9, 16'h1111);
    wr[1] = 1'b1; addr[1] = 16'd9; dout[1] = 16'h5555;
    @(posedge Clock);
    #1;
    chk("abort_busy", {15'd0, done[1]}, 16'd0);
    #2 Reset = 1'b1;
    #1;
    chk("abort_done", {15'd0, done[1]}, 16'd1);
    chk("abort_din", din[1], 16'h0000);
    wr[1] = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    access(1, 1'b0, 16'd9, 16'h0, st);
    chk("abort_mem", din[1], 16'h1111);

    // one wait state: 3 loads, 2 stores
    preload(2, 16'd1, 16'h0A0A);
    access(2, 1'b1, 16'd2, 16'hC0DE, st);
    chk("ws1_stall", 16'(st), 16'd1);
    access(2, 1'b0, 16'd1, 16'h0, st);
    chk("ws1_ld1", din[2], 16'h0A0A);
    access(2, 1'b1, 16'd4, 16'hFACE, st);
    access(2, 1'b0, 16'd2, 16'h0, st);
    chk("ws1_ld2", din[2], 16'hC0DE);
    access(2, 1'b0, 16'd4, 16'h0, st);
    chk("ws1_ld3", din[2], 16'hFACE);
`ifdef DMEM_STATS_EN
    chk("read_cnt", rc[2], 16'd3);
    chk("write_cnt", wc[2], 16'd2);
    chk("stall_cnt", sc[2], 16'd5);
    chk("ws0_stall_cnt", sc[0], 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
